fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
- Multi-cycle control FSM that owns the program counter and sequences each instruction: fetch, execute, optional memory access, write-back.
- Drives `pc` into the combinational instruction decoder and latches the decoded opcode, format and jump target.
- Issues enables to the ALU, the register file and data memory, and resolves jumps and branches.
- Sits between the instruction decoder and the datapath; it is the only writer of `pc`.

Parameters:
- PC_W, 16, program counter width.
- START_PC, 0, PC value loaded at reset.
- MEM_TIMEOUT, 15, maximum cycles `mem_req` may stay high without `mem_ack` before faulting. Legal range is 1..255.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin execution from IDLE; single-cycle pulse or level
- opcode  in  4  decoder opcode for current `pc`
- format  in  2  decoder format: 00 C, 01 I, 10 M, 11 X
- jmp_loc  in  PC_W  decoder jump/branch target for current `pc`
- flag_eq  in  1  datapath compare: operand1 == operand2; valid during EXEC
- flag_lt  in  1  datapath compare: operand1 < operand2; valid during EXEC
- mem_ack  in  1  data memory completion
- pc  out  PC_W  program counter
- ir_opcode  out  4  latched opcode of the instruction in flight
- alu_en  out  1  ALU operate strobe
- reg_we  out  1  register file write enable
- mem_req  out  1  data memory request
- mem_we  out  1  1 = store, 0 = load; valid while `mem_req` is high
- busy  out  1  high in FETCH, EXEC, MEM, WB
- done  out  1  high in HALTED
- err  out  1  high in ERROR
- retired  out  16  retired-instruction count, saturating

Behaviour:
Reset (asynchronous, `rst_n` = 0):
- Enter IDLE; `pc` = START_PC.
- `ir_opcode`, `retired` and all strobes/status = 0.
- Takes effect mid-instruction immediately; any in-flight memory request is abandoned.

Opcode classes:
- ALU-write: LIM 4, MVB 5, MVF 6, ADD 7, SUB 8, SFT 9, INC D.
- Load: LB 0, LHB 1.
- Store: STR 3.
- Jump: JMP 2.
- Branch: BNE A, BEQ B, BLT C.
- Halt: E.
- NOP: F.

States:
- IDLE: all strobes 0. `start` = 1 moves to FETCH.
- FETCH (1 cycle): latch `opcode` into `ir_opcode`, and `jmp_loc`/`format` into internal regs. Go to EXEC.
- EXEC (1 cycle): `alu_en` = 1 for ALU-write and Branch classes. Next state by class:
  - ALU-write: WB.
  - Load/Store: MEM.
  - Jump: `pc` <= latched target, then FETCH.
  - Branch: taken if BNE & !`flag_eq`, BEQ & `flag_eq`, or BLT & `flag_lt`. Taken: `pc` <= target; else `pc` <= `pc`+1. Then FETCH.
  - NOP: `pc` <= `pc`+1, then FETCH.
  - Halt: HALTED; `pc` unchanged.
- MEM:
  - `mem_req` = 1, `mem_we` = 1 for Store only.
  - Wait counter starts at 0 on entry and increments each cycle without `mem_ack`.
  - `mem_ack` sampled high: Load goes to WB; Store does `pc` <= `pc`+1 and goes to FETCH.
  - Counter reaching MEM_TIMEOUT with no ack: ERROR, `mem_req` drops.
  - An ack arriving on the same cycle the counter reaches the limit wins.
- WB (1 cycle): `reg_we` = 1, `pc` <= `pc`+1, then FETCH.
- HALTED: `done` = 1. Terminal until reset; `start` is ignored.
- ERROR: `err` = 1. Terminal until reset; `pc` frozen at the faulting instruction.

Rules:
- `pc`+1 wraps from all-ones to 0.
- `mem_ack` outside MEM is ignored; `start` outside IDLE is ignored.
- `retired` += 1 on every transition into FETCH from EXEC, MEM or WB, and on entry to HALTED. It saturates at 0xFFFF; ERROR does not retire.
- All outputs are Moore, decoded from state and latched opcode; no input-to-output combinational path.
- Cycles per instruction:
  - Jump, branch, NOP, halt: 2.
  - ALU-write: 3.
  - Store: 3 + wait cycles.
  - Load: 4 + wait cycles.
- Undefined `format` values (X) are don't-care; class is decided by opcode alone.

Test Plan:
1. Reset with `rst_n` low, then release, no `start` -> stays IDLE, `pc` = 0, all outputs 0; then `start` pulse -> FETCH on the next cycle.
2. ADD (opcode 7) at pc 5 -> `alu_en` high 1 cycle, then `reg_we` high 1 cycle, `pc` = 6, `retired` +1, 3 cycles total.
3. BEQ at pc 9, `jmp_loc` = 30: with `flag_eq` = 1 -> `pc` = 30; with `flag_eq` = 0 -> `pc` = 10. JMP with `jmp_loc` = 3 -> `pc` = 3.
4. LB with `mem_ack` after 4 wait cycles -> `mem_req` high 5 cycles with `mem_we` = 0, then `reg_we`, `pc`+1. STR with immediate ack -> `mem_we` = 1 for 1 cycle, no `reg_we`.
5. STR with no ack and MEM_TIMEOUT = 15 -> `mem_req` drops after 15 cycles, `err` = 1, `pc` frozen; later `mem_ack` and `start` have no effect until `rst_n` pulse.
6. HALT -> `done` = 1, `busy` = 0, `retired` incremented. START_PC = 0xFFFF with NOP -> `pc` wraps to 0x0000. Reset asserted mid-MEM -> `mem_req` = 0 immediately.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Multi-cycle fetch/execute/memory/write-back sequencer.
// Owns the program counter and issues datapath strobes.
module fetch_sequencer #(
  parameter int unsigned     PC_W        = 16,
  parameter logic [PC_W-1:0] START_PC    = '0,
  parameter int unsigned     MEM_TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [3:0]      opcode,
  input  logic [1:0]      format,
  input  logic [PC_W-1:0] jmp_loc,
  input  logic            flag_eq,
  input  logic            flag_lt,
  input  logic            mem_ack,
  output logic [PC_W-1:0] pc,
  output logic [3:0]      ir_opcode,
  output logic            alu_en,
  output logic            reg_we,
  output logic            mem_req,
  output logic            mem_we,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic [15:0]     retired
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_EXEC, S_MEM,
    S_WB, S_HALTED, S_ERROR
  } state_t;

  localparam logic [3:0] OP_JMP = 4'h2;
  localparam logic [3:0] OP_STR = 4'h3;
  localparam logic [3:0] OP_BNE = 4'hA;
  localparam logic [3:0] OP_BEQ = 4'hB;
  localparam logic [3:0] OP_BLT = 4'hC;
  localparam logic [3:0] OP_HLT = 4'hE;

  localparam logic [7:0] CNT_LAST =
    8'(MEM_TIMEOUT - 1);

  function automatic logic is_alu(
    input logic [3:0] op);
    return op inside {4'h4, 4'h5, 4'h6,
      4'h7, 4'h8, 4'h9, 4'hD};
  endfunction

  function automatic logic is_ld(
    input logic [3:0] op);
    return op inside {4'h0, 4'h1};
  endfunction

  function automatic logic is_br(
    input logic [3:0] op);
    return op inside {OP_BNE, OP_BEQ, OP_BLT};
  endfunction

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d, pc_inc;
  logic [PC_W-1:0] tgt_q, tgt_d;
  logic [3:0]      ir_q, ir_d;
  logic [1:0]      fmt_q, fmt_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [15:0]     ret_q;
  logic            ret_inc;
  logic            taken;
  logic alu_en_q, reg_we_q, mem_req_q;
  logic mem_we_q, busy_q, done_q, err_q;

  assign pc_inc = pc_q + PC_W'(1);

  assign taken =
    (ir_q == OP_BNE && !flag_eq) ||
    (ir_q == OP_BEQ &&  flag_eq) ||
    (ir_q == OP_BLT &&  flag_lt);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    tgt_d   = tgt_q;
    ir_d    = ir_q;
    fmt_d   = fmt_q;
    cnt_d   = cnt_q;
    ret_inc = 1'b0;
    unique case (state_q)
      S_IDLE:
        if (start) state_d = S_FETCH;
      S_FETCH: begin
        ir_d    = opcode;
        tgt_d   = jmp_loc;
        fmt_d   = format;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        unique case (1'b1)
          is_alu(ir_q):
            state_d = S_WB;
          is_ld(ir_q), ir_q == OP_STR: begin
            cnt_d   = '0;
            state_d = S_MEM;
          end
          ir_q == OP_JMP: begin
            pc_d    = tgt_q;
            state_d = S_FETCH;
            ret_inc = 1'b1;
          end
          is_br(ir_q): begin
            pc_d    = taken ? tgt_q : pc_inc;
            state_d = S_FETCH;
            ret_inc = 1'b1;
          end
          ir_q == OP_HLT: begin
            state_d = S_HALTED;
            ret_inc = 1'b1;
          end
          default: begin
            pc_d    = pc_inc;
            state_d = S_FETCH;
            ret_inc = 1'b1;
          end
        endcase
      end
      S_MEM: begin
        // ack on the final permitted cycle still completes
        if (mem_ack) begin
          if (is_ld(ir_q)) begin
            state_d = S_WB;
          end else begin
            pc_d    = pc_inc;
            state_d = S_FETCH;
            ret_inc = 1'b1;
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_ERROR;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_WB: begin
        pc_d    = pc_inc;
        state_d = S_FETCH;
        ret_inc = 1'b1;
      end
      default: ;
    endcase
  end

  // strobes are registered from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      pc_q      <= START_PC;
      tgt_q     <= '0;
      ir_q      <= '0;
      fmt_q     <= '0;
      cnt_q     <= '0;
      ret_q     <= '0;
      alu_en_q  <= 1'b0;
      reg_we_q  <= 1'b0;
      mem_req_q <= 1'b0;
      mem_we_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      tgt_q     <= tgt_d;
      ir_q      <= ir_d;
      fmt_q     <= fmt_d;
      cnt_q     <= cnt_d;
      if (ret_inc && ret_q != 16'hFFFF)
        ret_q <= ret_q + 16'd1;
      alu_en_q  <= state_d == S_EXEC &&
                   (is_alu(ir_d) || is_br(ir_d));
      reg_we_q  <= state_d == S_WB;
      mem_req_q <= state_d == S_MEM;
      mem_we_q  <= state_d == S_MEM &&
                   ir_d == OP_STR;
      busy_q    <= state_d inside {S_FETCH,
                   S_EXEC, S_MEM, S_WB};
      done_q    <= state_d == S_HALTED;
      err_q     <= state_d == S_ERROR;
    end
  end

  assign pc        = pc_q;
  assign ir_opcode = ir_q;
  assign alu_en    = alu_en_q;
  assign reg_we    = reg_we_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign retired   = ret_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer.
// Expected values are hand-derived per instruction.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  opcode = '0;
  logic [1:0]  format = '0;
  logic [15:0] jmp_loc = '0;
  logic        flag_eq = 1'b0;
  logic        flag_lt = 1'b0;
  logic        mem_ack = 1'b0;
  logic [15:0] pc;
  logic [3:0]  ir_opcode;
  logic        alu_en, reg_we, mem_req, mem_we;
  logic        busy, done, err;
  logic [15:0] retired;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fetch_sequencer #(
    .PC_W(16), .START_PC(16'h0000),
    .MEM_TIMEOUT(15)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .opcode(opcode), .format(format),
    .jmp_loc(jmp_loc), .flag_eq(flag_eq),
    .flag_lt(flag_lt), .mem_ack(mem_ack),
    .pc(pc), .ir_opcode(ir_opcode),
    .alu_en(alu_en), .reg_we(reg_we),
    .mem_req(mem_req), .mem_we(mem_we),
    .busy(busy), .done(done), .err(err),
    .retired(retired)
  );

  task automatic check(input string tag,
    input logic [31:0] got,
    input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h",
        tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // from FETCH: run a 2-cycle instruction
  task automatic run2(input logic [3:0] op,
    input logic [15:0] tgt,
    input logic eq, input logic lt);
    opcode  = op;
    jmp_loc = tgt;
    flag_eq = eq;
    flag_lt = lt;
    step();
    step();
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    step();
    step();
    check("rst_pc", pc, 0);
    check("rst_busy", busy, 0);
    check("rst_ret", retired, 0);
    check("rst_ir", ir_opcode, 0);
    check("rst_strb",
      {alu_en, reg_we, mem_req, mem_we, done, err},
      0);
    rst_n = 1'b1;
    step();
    step();
    check("idle_busy", busy, 0);
    check("idle_pc", pc, 0);

    // JMP 5 launched by start
    start   = 1'b1;
    opcode  = 4'h2;
    jmp_loc = 16'd5;
    step();
    start = 1'b0;
    check("fetch_busy", busy, 1);
    check("fetch_alu", alu_en, 0);
    step();
    check("exec_ir", ir_opcode, 2);
    check("jmp_alu", alu_en, 0);
    step();
    check("jmp5_pc", pc, 5);
    check("jmp5_ret", retired, 1);

    // ADD at 5
    opcode = 4'h7;
    step();
    check("add_alu", alu_en, 1);
    check("add_we0", reg_we, 0);
    step();
    check("add_we", reg_we, 1);
    check("add_alu0", alu_en, 0);
    check("add_pcwb", pc, 5);
    step();
    check("add_pc", pc, 6);
    check("add_we1", reg_we, 0);
    check("add_ret", retired, 2);

    // branches
    run2(4'h2, 16'd9, 0, 0);
    check("jmp9", pc, 9);
    opcode  = 4'hB;
    jmp_loc = 16'd30;
    flag_eq = 1'b1;
    step();
    check("beq_alu", alu_en, 1);
    step();
    check("beq_t", pc, 30);
    check("beq_ret", retired, 4);
    run2(4'h2, 16'd9, 0, 0);
    run2(4'hB, 16'd30, 0, 0);
    check("beq_nt", pc, 10);
    run2(4'hA, 16'd40, 0, 0);
    check("bne_t", pc, 40);
    run2(4'hC, 16'd50, 1, 0);
    check("blt_nt", pc, 41);
    run2(4'hC, 16'd50, 0, 1);
    check("blt_t", pc, 50);
    run2(4'h2, 16'd3, 0, 0);
    check("jmp3", pc, 3);
    check("br_ret", retired, 10);

    // LB with 4 wait cycles
    opcode = 4'h0;
    step();
    step();
    for (int i = 0; i < 4; i++) begin
      check("lb_req", mem_req, 1);
      check("lb_we", mem_we, 0);
      step();
    end
    check("lb_req5", mem_req, 1);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    check("lb_req0", mem_req, 0);
    check("lb_rwe", reg_we, 1);
    check("lb_pcwb", pc, 3);
    step();
    check("lb_pc", pc, 4);
    check("lb_ret", retired, 11);

    // STR immediate ack
    opcode = 4'h3;
    step();
    step();
    check("st_req", mem_req, 1);
    check("st_we", mem_we, 1);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    check("st_req0", mem_req, 0);
    check("st_we0", mem_we, 0);
    check("st_rwe", reg_we, 0);
    check("st_pc", pc, 5);
    check("st_ret", retired, 12);

    // wrap via NOP at 0xFFFF
    run2(4'h2, 16'hFFFF, 0, 0);
    check("jmp_ff", pc, 16'hFFFF);
    run2(4'hF, 16'h0, 0, 0);
    check("nop_wrap", pc, 0);

    // HALT
    opcode = 4'hE;
    step();
    step();
    check("hlt_done", done, 1);
    check("hlt_busy", busy, 0);
    check("hlt_pc", pc, 0);
    check("hlt_ret", retired, 15);
    start = 1'b1;
    step();
    step();
    start = 1'b0;
    check("hlt_stay", done, 1);

    // STR ack on last allowed cycle
    do_reset();
    check("rst2_ret", retired, 0);
    opcode = 4'h3;
    start  = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    for (int i = 0; i < 14; i++) step();
    check("lim_req", mem_req, 1);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    check("lim_err", err, 0);
    check("lim_pc", pc, 1);

    // STR timeout
    do_reset();
    opcode = 4'h3;
    start  = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    for (int i = 0; i < 15; i++) begin
      check("to_req", mem_req, 1);
      step();
    end
    check("to_req0", mem_req, 0);
    check("to_err", err, 1);
    check("to_busy", busy, 0);
    check("to_pc", pc, 0);
    check("to_ret", retired, 0);
    mem_ack = 1'b1;
    start   = 1'b1;
    step();
    step();
    mem_ack = 1'b0;
    start   = 1'b0;
    check("to_stay", err, 1);
    check("to_pc2", pc, 0);

    // reset mid-MEM
    do_reset();
    check("rst3_err", err, 0);
    opcode = 4'h1;
    start  = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    check("mid_req", mem_req, 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_req0", mem_req, 0);
    check("mid_busy", busy, 0);
    check("mid_pc", pc, 0);
    step();
    rst_n = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d",
      checks, failures);
    $finish;
  end

endmodule
